fadd_hp_operand_stage: RTL and testbench
========================================

# fadd_hp_operand_stage

Operand issue stage sitting directly upstream of the half-precision floating-point adder. Accepts packed 16-bit IEEE-754 half-precision operand pairs plus an add/subtract select over a valid/ready handshake, classifies each operand, computes the result for special cases, and buffers everything in a small FIFO. Its head entry presents the unpacked sign/exponent/mantissa fields the adder consumes. The adder handles only normal operands, so this stage resolves zero, denormal, infinity and NaN inputs ahead of it.

## Interface
- DEPTH, 2, FIFO entries; power of two, 2..8.
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- in_valid  in  1  operand pair offered.
- in_ready  out  1  stage can accept; equals !full.
- in_add  in  1  1 = A+B, 0 = A−B.
- in_a, in_b  in  [16:1]  packed operands: sign bit 16, exponent [15:11], mantissa [10:1].
- out_valid  out  1  head entry valid (count != 0).
- out_ready  in  1  downstream accepts head.
- out_add  out  1  stored add select.
- out_Sign_1, out_Exponent_1 [5:1], out_Mantissa_1 [10:1]  out  unpacked A.
- out_Sign_2, out_Exponent_2 [5:1], out_Mantissa_2 [10:1]  out  unpacked B, sign before add/sub adjustment.
- out_special  out  1  result predetermined; downstream selects out_special_result instead of the adder output.
- out_special_result  out  [16:1]  packed predetermined result; 16'h0000 when out_special = 0.
- count  out  [log2(DEPTH):0]  current occupancy.
- special_count  out  [8:1]  saturating count of pushed entries with out_special = 1.

## Operation
- Push: in_valid & in_ready. Pop: out_valid & out_ready. Push and pop may occur in the same cycle, including when full: push is blocked while full because in_ready = !full; pop still proceeds; there is no same-cycle bypass.
- Classification happens at push time and is stored per entry. Classes: zero (exp=0, man=0), denormal (exp=0, man≠0), inf (exp=31, man=0), NaN (exp=31, man≠0), normal.
- Denormals are flushed to signed zero before any further rule is applied.
- Effective B sign: sB_eff = sB XOR !in_add.
- Special-case priority:
  1. Either operand NaN → 16'h7E00.
  2. Both inf with sA ≠ sB_eff → 16'h7E00.
  3. Either operand inf → that inf, with the sign it carries into the sum (sB_eff for B).
  4. Both zero → {sA & sB_eff, 15'b0}.
  5. A zero → {sB_eff, B[15:1]}.
  6. B zero → A unchanged.
  7. Otherwise out_special = 0.
- Unpacked out_* fields always carry the raw input fields, even when out_special = 1.
- FIFO: circular buffer with read/write pointers wrapping modulo DEPTH.
- special_count: increments on each push with a special result; saturates at 255.

## Timing
- Latency: a pair pushed in cycle N appears at the head, with out_valid = 1, in cycle N+1 if the FIFO was empty.
- Output fields come from registered storage indexed by the read pointer; they hold steady while out_valid & !out_ready.
- count updates the cycle after push/pop; simultaneous push and pop leaves count unchanged.
- Reset (asynchronous, any time, including mid-transfer): count=0, pointers=0, special_count=0, out_valid=0, in_ready=1, all out_* data = 0. Buffered entries are discarded; the first push after reset release appears exactly one cycle later.
- Never drop or duplicate an entry; FIFO order is preserved.

## Test plan
- Normal pass-through: push A=16'h3C00, B=16'h4000, add=1 → next cycle out_valid=1, Sign_1=0, Exponent_1=5'd15, Mantissa_1=0, Exponent_2=5'd16, out_special=0.
- Specials: A=16'h7C00, B=16'h7C00, add=0 → out_special=1, result 16'h7E00. A=16'h0000, B=16'h4000, add=0 → result 16'hC000. A=16'h0001 (denormal), B=16'h3C00, add=1 → result 16'h3C00.
- Backpressure, DEPTH=2: hold out_ready=0, push three pairs → in_ready=0 after the second push, count=2, third pair not accepted. Raise out_ready → entries pop in order.
- Full with simultaneous events: when full, assert out_ready and in_valid together → pop occurs, push blocked that cycle, count=1. Push completes the next cycle.
- Wrap-around: stream 20 pairs with random out_ready → outputs match a reference model in order; special_count equals the number of special pairs.
- Reset mid-operation: assert reset with count=2 → all outputs zero immediately, no stale entry after release. Saturation: push 300 NaN pairs → special_count=255.

Source files
------------

// File: rtl/fadd_hp_operand_stage_if.sv
// Operand-issue handshake bundle: producer side (in_*) and the
// head-of-FIFO side (out_*) presented to the half-precision adder.
interface fadd_hp_operand_stage_if;
    logic        in_valid;
    logic        in_ready;
    logic        in_add;
    logic [16:1] in_a;
    logic [16:1] in_b;

    logic        out_valid;
    logic        out_ready;
    logic        out_add;
    logic        out_Sign_1;
    logic [5:1]  out_Exponent_1;
    logic [10:1] out_Mantissa_1;
    logic        out_Sign_2;
    logic [5:1]  out_Exponent_2;
    logic [10:1] out_Mantissa_2;
    logic        out_special;
    logic [16:1] out_special_result;

    // Driver of operand pairs and consumer of the head entry.
    modport master (
        output in_valid, in_add, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_add,
               out_Sign_1, out_Exponent_1, out_Mantissa_1,
               out_Sign_2, out_Exponent_2, out_Mantissa_2,
               out_special, out_special_result
    );

    // The operand stage itself.
    modport slave (
        input  in_valid, in_add, in_a, in_b, out_ready,
        output in_ready, out_valid, out_add,
               out_Sign_1, out_Exponent_1, out_Mantissa_1,
               out_Sign_2, out_Exponent_2, out_Mantissa_2,
               out_special, out_special_result
    );
endinterface

// File: rtl/fadd_hp_operand_stage.sv
// Half-precision adder operand stage: classifies each incoming operand pair,
// resolves zero/denormal/inf/NaN cases into a predetermined result, and
// buffers pairs in a DEPTH-entry circular FIFO whose head feeds the adder.
module fadd_hp_operand_stage #(
    parameter int unsigned DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    fadd_hp_operand_stage_if.slave  bus,
    output logic [$clog2(DEPTH):0]  count,
    output logic [8:1]              special_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef struct packed {
        logic        add;
        logic [16:1] a;
        logic [16:1] b;
        logic        special;
        logic [16:1] result;
    } entry_t;

    entry_t          mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [8:1]      spc_q, spc_d;

    logic            full;
    logic            push;
    logic            pop;
    entry_t          in_entry;
    entry_t          head;

    // Operand classification fields
    logic            sa, sb_eff;
    logic            a_zero, a_inf, a_nan;
    logic            b_zero, b_inf, b_nan;

    assign full         = (count_q == FULL_CNT);
    assign bus.in_ready = !full;
    assign bus.out_valid = (count_q != '0);
    assign push         = bus.in_valid && !full;
    assign pop          = bus.out_valid && bus.out_ready;

    // Classify both operands and resolve the special-case result for the incoming pair.
    // Denormals are folded into the zero class (exp == 0) so the flush happens before any rule.
    always_comb begin
        sa     = bus.in_a[16];
        sb_eff = bus.in_b[16] ^ ~bus.in_add;

        a_zero = (bus.in_a[15:11] == 5'd0);
        a_inf  = (bus.in_a[15:11] == 5'h1F) && (bus.in_a[10:1] == '0);
        a_nan  = (bus.in_a[15:11] == 5'h1F) && (bus.in_a[10:1] != '0);
        b_zero = (bus.in_b[15:11] == 5'd0);
        b_inf  = (bus.in_b[15:11] == 5'h1F) && (bus.in_b[10:1] == '0);
        b_nan  = (bus.in_b[15:11] == 5'h1F) && (bus.in_b[10:1] != '0);

        in_entry         = '0;
        in_entry.add     = bus.in_add;
        in_entry.a       = bus.in_a;
        in_entry.b       = bus.in_b;
        in_entry.special = 1'b1;

        if (a_nan || b_nan) begin
            in_entry.result = 16'h7E00;
        end else if (a_inf && b_inf && (sa != sb_eff)) begin
            in_entry.result = 16'h7E00;
        end else if (a_inf) begin
            in_entry.result = {sa, 15'h7C00};
        end else if (b_inf) begin
            in_entry.result = {sb_eff, 15'h7C00};
        end else if (a_zero && b_zero) begin
            in_entry.result = {sa & sb_eff, 15'h0000};
        end else if (a_zero) begin
            in_entry.result = {sb_eff, bus.in_b[15:1]};
        end else if (b_zero) begin
            in_entry.result = bus.in_a;
        end else begin
            in_entry.special = 1'b0;
            in_entry.result  = '0;
        end
    end

    // Next-state for pointers, occupancy and the saturating special counter.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        spc_d    = spc_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if (push && in_entry.special && (spc_q != 8'hFF)) begin
            spc_d = spc_q + 8'd1;
        end
    end

    // Control registers with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            spc_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            spc_q    <= spc_d;
        end
    end

    // Entry storage; written at the write pointer on every accepted push.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[wr_ptr_q] <= in_entry;
        end
    end

    // Head presentation; forced to zero while empty so stale slots never leak out.
    always_comb begin
        head = '0;
        if (bus.out_valid) begin
            head = mem_q[rd_ptr_q];
        end
    end

    assign bus.out_add            = head.add;
    assign bus.out_Sign_1         = head.a[16];
    assign bus.out_Exponent_1     = head.a[15:11];
    assign bus.out_Mantissa_1     = head.a[10:1];
    assign bus.out_Sign_2         = head.b[16];
    assign bus.out_Exponent_2     = head.b[15:11];
    assign bus.out_Mantissa_2     = head.b[10:1];
    assign bus.out_special        = head.special;
    assign bus.out_special_result = head.result;

    assign count         = count_q;
    assign special_count = spc_q;

endmodule

// File: tb/tb_fadd_hp_operand_stage.sv
// Directed bench for fadd_hp_operand_stage (DEPTH = 2).
module tb_fadd_hp_operand_stage;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] count;
    logic [8:1] special_count;

    always #5 clk = ~clk;

    fadd_hp_operand_stage_if bus();

    fadd_hp_operand_stage #(.DEPTH(2)) dut (
        .clk           (clk),
        .reset         (reset),
        .bus           (bus.slave),
        .count         (count),
        .special_count (special_count)
    );

    int checks = 0;
    int errors = 0;

    // Hand-computed vectors: A, B, add select, expected special flag and result.
    logic [16:1] va   [14] = '{16'h3C00, 16'h7C00, 16'h0000, 16'h0001, 16'h4000, 16'hFC00, 16'h3C00,
                               16'h8000, 16'h8000, 16'h4248, 16'h4248, 16'h7C00, 16'h7C00, 16'hC500};
    logic [16:1] vb   [14] = '{16'h4000, 16'h7C00, 16'h4000, 16'h3C00, 16'h7C01, 16'h3C00, 16'h7C00,
                               16'h8000, 16'h8000, 16'h0000, 16'h83FF, 16'hFC00, 16'hFC00, 16'h3555};
    logic        vadd [14] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0,
                               1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic        vsp  [14] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                               1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [16:1] vres [14] = '{16'h0000, 16'h7E00, 16'hC000, 16'h3C00, 16'h7E00, 16'hFC00, 16'hFC00,
                               16'h8000, 16'h0000, 16'h4248, 16'h4248, 16'h7E00, 16'h7C00, 16'h0000};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int idx, input logic v);
        bus.in_valid = v;
        bus.in_a     = va[idx];
        bus.in_b     = vb[idx];
        bus.in_add   = vadd[idx];
    endtask

    task automatic check_head(input string tag, input int idx);
        logic [16:1] a;
        logic [16:1] b;
        a = va[idx];
        b = vb[idx];
        chk($sformatf("%s[%0d].valid", tag, idx),   bus.out_valid,        1);
        chk($sformatf("%s[%0d].add", tag, idx),     bus.out_add,          vadd[idx]);
        chk($sformatf("%s[%0d].s1", tag, idx),      bus.out_Sign_1,       a[16]);
        chk($sformatf("%s[%0d].e1", tag, idx),      bus.out_Exponent_1,   a[15:11]);
        chk($sformatf("%s[%0d].m1", tag, idx),      bus.out_Mantissa_1,   a[10:1]);
        chk($sformatf("%s[%0d].s2", tag, idx),      bus.out_Sign_2,       b[16]);
        chk($sformatf("%s[%0d].e2", tag, idx),      bus.out_Exponent_2,   b[15:11]);
        chk($sformatf("%s[%0d].m2", tag, idx),      bus.out_Mantissa_2,   b[10:1]);
        chk($sformatf("%s[%0d].special", tag, idx), bus.out_special,      vsp[idx]);
        chk($sformatf("%s[%0d].result", tag, idx),  bus.out_special_result, vres[idx]);
    endtask

    initial begin
        int pushed;
        int popped;
        int sat_pushes;

        // Reset state
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_add    = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b0;
        #12;
        chk("rst.count",    count, 0);
        chk("rst.valid",    bus.out_valid, 0);
        chk("rst.ready",    bus.in_ready, 1);
        chk("rst.spc",      special_count, 0);
        chk("rst.result",   bus.out_special_result, 0);
        chk("rst.exp1",     bus.out_Exponent_1, 0);
        reset = 1'b0;
        tick();

        // Normal pass-through, one-cycle latency
        drive(0, 1'b1);
        tick();
        bus.in_valid = 1'b0;
        chk("pass.exp1", bus.out_Exponent_1, 5'd15);
        chk("pass.exp2", bus.out_Exponent_2, 5'd16);
        chk("pass.count", count, 1);
        check_head("pass", 0);
        bus.out_ready = 1'b1;
        tick();
        chk("pass.drain_count", count, 0);
        chk("pass.drain_valid", bus.out_valid, 0);
        chk("pass.drain_result", bus.out_special_result, 0);

        // Special cases, one at a time
        for (int i = 1; i <= 8; i++) begin
            bus.out_ready = 1'b0;
            drive(i, 1'b1);
            tick();
            bus.in_valid = 1'b0;
            check_head("spec", i);
            bus.out_ready = 1'b1;
            tick();
        end
        chk("spec.count", count, 0);
        chk("spec.spc", special_count, 8);

        // Backpressure and full with simultaneous push/pop
        bus.out_ready = 1'b0;
        drive(9, 1'b1);
        tick();
        chk("bp.count1", count, 1);
        chk("bp.ready1", bus.in_ready, 1);
        drive(10, 1'b1);
        tick();
        chk("bp.count2", count, 2);
        chk("bp.ready2", bus.in_ready, 0);
        drive(11, 1'b1);
        tick();
        chk("bp.blocked_count", count, 2);
        check_head("bp.hold", 9);
        bus.out_ready = 1'b1;
        tick();
        chk("bp.full_pop_count", count, 1);
        check_head("bp.after_pop", 10);
        bus.out_ready = 1'b0;
        tick();
        chk("bp.late_push_count", count, 2);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        chk("bp.pop2_count", count, 1);
        check_head("bp.third", 11);
        tick();
        chk("bp.empty_count", count, 0);
        chk("bp.spc", special_count, 11);

        // Asynchronous reset mid-operation
        bus.out_ready = 1'b0;
        drive(1, 1'b1);
        tick();
        drive(13, 1'b1);
        tick();
        bus.in_valid = 1'b0;
        chk("mrst.pre_count", count, 2);
        #2;
        reset = 1'b1;
        #1;
        chk("mrst.count",  count, 0);
        chk("mrst.valid",  bus.out_valid, 0);
        chk("mrst.ready",  bus.in_ready, 1);
        chk("mrst.spc",    special_count, 0);
        chk("mrst.result", bus.out_special_result, 0);
        chk("mrst.special", bus.out_special, 0);
        chk("mrst.exp1",   bus.out_Exponent_1, 0);
        chk("mrst.man2",   bus.out_Mantissa_2, 0);
        #2;
        reset = 1'b0;
        tick();
        drive(13, 1'b1);
        tick();
        bus.in_valid = 1'b0;
        chk("mrst.post_count", count, 1);
        check_head("mrst.post", 13);
        bus.out_ready = 1'b1;
        tick();
        chk("mrst.post_empty", bus.out_valid, 0);

        // Wrap-around stream with random backpressure
        reset = 1'b1;
        #1;
        reset = 1'b0;
        tick();
        pushed = 0;
        popped = 0;
        for (int cyc = 0; cyc < 500 && popped < 20; cyc++) begin
            if (pushed < 20) begin
                drive(pushed % 14, 1'b1);
            end else begin
                bus.in_valid = 1'b0;
            end
            bus.out_ready = 1'($urandom_range(0, 1));
            if (bus.out_valid && bus.out_ready) begin
                check_head("stream", popped % 14);
                popped++;
            end
            if (bus.in_valid && bus.in_ready) begin
                pushed++;
            end
            tick();
        end
        bus.in_valid = 1'b0;
        chk("stream.popped", popped, 20);
        chk("stream.count", count, 0);
        chk("stream.spc", special_count, 17);

        // Saturation of the special counter with back-to-back NaN pairs
        bus.out_ready = 1'b1;
        drive(4, 1'b1);
        sat_pushes = 0;
        for (int i = 0; i < 300; i++) begin
            if (bus.in_ready) begin
                sat_pushes++;
            end
            tick();
            if (sat_pushes == 200) chk("sat.mid", special_count, 217);
            if (sat_pushes == 237) chk("sat.254", special_count, 254);
            if (sat_pushes == 238) chk("sat.255", special_count, 255);
            if (sat_pushes == 239) chk("sat.hold", special_count, 255);
        end
        bus.in_valid = 1'b0;
        chk("sat.pushes", sat_pushes, 300);
        chk("sat.final", special_count, 255);
        tick();
        chk("sat.drain", count, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
